// File: rtl/bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_if
// Purpose  : Request/grant and shared-bus status signals between the bus
//            masters and the round-robin bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface bus_arbiter_if #(
    parameter int NUM_MASTERS = 4
);
    localparam int c_OW_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [NUM_MASTERS-1:0] request;
    logic [NUM_MASTERS-1:0] granted;
    logic                   begin_transactionIN;
    logic                   end_transactionIN;
    logic                   data_validIN;
    logic                   errorIN;
    logic                   errorOUT;
    logic [c_OW_W-1:0]      bus_owner;
    logic                   bus_active;

    // Requester / bus side
    modport master (
        output request, begin_transactionIN, end_transactionIN, data_validIN, errorIN,
        input  granted, errorOUT, bus_owner, bus_active
    );

    // Arbiter side
    modport slave (
        input  request, begin_transactionIN, end_transactionIN, data_validIN, errorIN,
        output granted, errorOUT, bus_owner, bus_active
    );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Round-robin arbiter for the shared bus; holds a grant for a whole
//            transaction, withdraws unused grants and aborts hung transfers.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
    parameter int NUM_MASTERS     = 4,
    parameter int BEGIN_TIMEOUT   = 4,
    parameter int WATCHDOG_CYCLES = 256
) (
    input  wire logic    clock,
    input  wire logic    reset,
    bus_arbiter_if.slave bus
);
    localparam int c_OW_W = (NUM_MASTERS > 1)     ? $clog2(NUM_MASTERS)     : 1;
    localparam int c_BC_W = (BEGIN_TIMEOUT > 1)   ? $clog2(BEGIN_TIMEOUT)   : 1;
    localparam int c_WD_W = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;

    localparam logic [c_BC_W-1:0]      c_BC_MAX   = c_BC_W'(BEGIN_TIMEOUT - 1);
    localparam logic [c_WD_W-1:0]      c_WD_MAX   = c_WD_W'(WATCHDOG_CYCLES - 1);
    localparam logic [c_OW_W-1:0]      c_LAST_RST = c_OW_W'(NUM_MASTERS - 1);
    localparam logic [NUM_MASTERS-1:0] c_ONE      = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_GRANT  = 2'd1;
    localparam logic [1:0] c_ST_ACTIVE = 2'd2;
    localparam logic [1:0] c_ST_ERROR  = 2'd3;

    logic [1:0]             r_state;
    logic [NUM_MASTERS-1:0] r_granted;
    logic [c_OW_W-1:0]      r_bus_owner;
    logic [c_OW_W-1:0]      r_last_owner;
    logic                   r_bus_active;
    logic                   r_error_out;
    logic [c_BC_W-1:0]      r_begin_cnt;
    logic [c_WD_W-1:0]      r_wd_cnt;

    logic [c_OW_W-1:0]      w_sel;
    int                     w_best;
    logic                   w_to_idle;

    // Pick the requester with the smallest distance above the last owner
    always_comb begin
        w_sel  = '0;
        w_best = NUM_MASTERS;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (bus.request[i] &&
                (((i + NUM_MASTERS - 1 - int'(r_last_owner)) % NUM_MASTERS) < w_best)) begin
                w_best = (i + NUM_MASTERS - 1 - int'(r_last_owner)) % NUM_MASTERS;
                w_sel  = c_OW_W'(i);
            end
        end
    end

    // errorIN outranks every other transition; end beats watchdog expiry
    always_comb begin
        w_to_idle = 1'b0;
        case (r_state)
            c_ST_IDLE:   w_to_idle = 1'b0;
            c_ST_GRANT:  w_to_idle = bus.errorIN ||
                                     (!bus.begin_transactionIN && (r_begin_cnt >= c_BC_MAX));
            c_ST_ACTIVE: w_to_idle = bus.errorIN || bus.end_transactionIN;
            default:     w_to_idle = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= c_ST_IDLE;
            r_granted    <= '0;
            r_bus_owner  <= '0;
            r_last_owner <= c_LAST_RST;
            r_bus_active <= 1'b0;
            r_error_out  <= 1'b0;
            r_begin_cnt  <= '0;
            r_wd_cnt     <= '0;
        end else if (w_to_idle) begin
            r_state      <= c_ST_IDLE;
            r_granted    <= '0;
            r_bus_owner  <= '0;
            r_bus_active <= 1'b0;
            r_error_out  <= 1'b0;
        end else begin
            r_error_out <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (|bus.request) begin
                        r_state      <= c_ST_GRANT;
                        r_granted    <= c_ONE << w_sel;
                        r_bus_owner  <= w_sel;
                        r_last_owner <= w_sel;
                        r_bus_active <= 1'b1;
                        r_begin_cnt  <= '0;
                    end
                end
                c_ST_GRANT: begin
                    if (bus.begin_transactionIN) begin
                        r_state  <= c_ST_ACTIVE;
                        r_wd_cnt <= '0;
                    end else begin
                        r_begin_cnt <= r_begin_cnt + 1'b1;
                    end
                end
                c_ST_ACTIVE: begin
                    if (bus.data_validIN) begin
                        r_wd_cnt <= '0;
                    end else if (r_wd_cnt >= c_WD_MAX) begin
                        r_state      <= c_ST_ERROR;
                        r_error_out  <= 1'b1;
                        r_bus_active <= 1'b0;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.granted    = r_granted;
    assign bus.bus_owner  = r_bus_owner;
    assign bus.bus_active = r_bus_active;
    assign bus.errorOUT   = r_error_out;

endmodule
`default_nettype wire
